mmio_requester: RTL and testbench
=================================

// Module: mmio_requester
// PURPOSE
//  PSL-side MMIO initiator: accepts one host command, drives a single-cycle MMIO request
//  (MMIOInterfaceInput) into the AFU, waits for ack, and returns read data/status.
//  Used as the host/PSL stand-in in simulation and as the MMIO master in loopback builds.
//  Exactly one MMIO transaction is outstanding at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles to wait for ack after valid before aborting (>=2)
// PORTS
//  clock            input   1       rising-edge clock
//  reset_n          input   1       async, active-low reset
//  req_valid        input   1       host command present
//  req_ready        output  1       requester can accept command (high only in IDLE)
//  req_cfg          input   1       1 = config-space access
//  req_read         input   1       1 = read, 0 = write
//  req_doubleword   input   1       1 = 64-bit, 0 = 32-bit access
//  req_address      input   [0:23]  MMIO word address
//  req_data         input   [0:63]  write data (word access uses [32:63])
//  mmio_out         output  MMIOInterfaceInput   request to AFU
//  mmio_in          input   MMIOInterfaceOutput  ack/data/data_parity from AFU
//  resp_valid       output  1       one-cycle completion pulse
//  resp_data        output  [0:63]  read data (0 for writes/timeouts)
//  resp_parity_err  output  1       read data parity mismatch, qualified by resp_valid
//  resp_timeout     output  1       no ack within TIMEOUT_CYCLES, qualified by resp_valid
//  stray_ack        output  1       one-cycle pulse: ack seen while no request outstanding
// BEHAVIOUR
//  Reset: state IDLE; all mmio_out fields 0; req_ready 1; resp_* 0; stray_ack 0.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE : req_ready=1; req_valid=1 latches all req_* fields, go ISSUE.
//   ISSUE: mmio_out.valid=1 for exactly this one cycle; cfg/read/doubleword/address driven;
//          address_parity = ~^address; write data: doubleword ? req_data :
//          {req_data[32:63], req_data[32:63]}; data_parity = ~^data (odd parity).
//          Read: mmio_out.data = 0, data_parity = 1. Timeout counter cleared. Go WAIT.
//   WAIT : mmio_out.valid=0; all other mmio_out fields hold last values. Counter +1/cycle.
//          mmio_in.ack=1 -> capture; go DONE. Counter reaches TIMEOUT_CYCLES-1 without
//          ack -> go DONE with timeout flag.
//   DONE : resp_valid=1 for one cycle; go IDLE next cycle (req_ready high again there).
//  Read capture: doubleword ? mmio_in.data : {32'h0, mmio_in.data[32:63]};
//   parity_err = (mmio_in.data_parity != ~^mmio_in.data), full 64 bits checked.
//  Writes: resp_data=0, parity_err=0 (returned ack data ignored).
//  Timeout: resp_timeout=1, resp_data=0, parity_err=0.
//  Ack on the same cycle as ISSUE is not a completion: ignored, stray_ack pulses next cycle.
//  Ack in IDLE/DONE: stray_ack pulses next cycle; no state change.
//  Ack in the timeout-expiry cycle: ack wins, resp_timeout=0.
//  Min latency: req accept (T) -> valid (T+1) -> ack at T+2 -> resp_valid at T+3.
//  Reset mid-transaction: immediate return to IDLE, mmio_out.valid=0, no resp_valid pulse.
//  Timeout counter width $clog2(TIMEOUT_CYCLES+1); never wraps (saturates until exit).
// TESTING
//  1 cfg dw read addr 0, AFU acks 2 cyc after valid with data=64'h1, parity 0
//    -> one valid pulse, resp_data=64'h1, parity_err=0, resp_valid 3 cyc after valid.
//  2 word write addr 24'h000010 data 64'h0000_0000_DEAD_BEEF
//    -> mmio_out.data=64'hDEADBEEF_DEADBEEF, data_parity=~^data; resp_data=0 on ack.
//  3 read with AFU driving data=64'h3, data_parity=0 -> resp_parity_err=1.
//  4 TIMEOUT_CYCLES=8, AFU never acks -> resp_valid with resp_timeout=1
//    8 cyc after valid; then ack pulse -> stray_ack=1, FSM stays IDLE.
//  5 reset_n low during WAIT, then ack -> no resp_valid, stray_ack on ack; req_ready=1.
//  6 back-to-back reqs held high -> valid pulses never overlap; 2nd issue only after DONE.

Source files
------------

// File: rtl/mmio_requester.sv
// mmio_requester: single-outstanding MMIO initiator. Takes one host command,
// issues a one-cycle request to the AFU, waits for ack or timeout, and returns
// read data, a parity check result and a timeout flag as a one-cycle response.

package mmio_pkg;

  // Request from the PSL side into the AFU (bit 0 is the most significant).
  typedef struct packed {
    logic        valid;
    logic        cfg;
    logic        read;
    logic        doubleword;
    logic [0:23] address;
    logic        address_parity;
    logic [0:63] data;
    logic        data_parity;
  } MMIOInterfaceInput;

  // Acknowledge and read data returned by the AFU.
  typedef struct packed {
    logic        ack;
    logic [0:63] data;
    logic        data_parity;
  } MMIOInterfaceOutput;

endpackage

module mmio_requester
  import mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_cfg,
  input  logic               req_read,
  input  logic               req_doubleword,
  input  logic [0:23]        req_address,
  input  logic [0:63]        req_data,
  output MMIOInterfaceInput  mmio_out,
  input  MMIOInterfaceOutput mmio_in,
  output logic               resp_valid,
  output logic [0:63]        resp_data,
  output logic               resp_parity_err,
  output logic               resp_timeout,
  output logic               stray_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last counter value of the wait window; reaching it without ack aborts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  MMIOInterfaceInput mmio_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_step;
  logic [0:63]       resp_data_reg;
  logic              resp_parity_err_reg;
  logic              resp_timeout_reg;
  logic              stray_reg;
  logic              accept;
  logic              ack_taken;
  logic              expire;
  logic [0:63]       wdata;
  logic [0:63]       rdata;

  // Counter saturates so it can never wrap back into the wait window.
  assign cnt_step  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign accept    = (state_reg == IDLE) && req_valid;
  assign ack_taken = (state_reg == WAIT) && mmio_in.ack;
  assign expire    = (state_reg == WAIT) && !mmio_in.ack && (cnt_step >= CNT_LAST);

  // Word writes replicate the low word into both halves of the data bus.
  assign wdata = req_read       ? 64'h0 :
                 req_doubleword ? req_data : {req_data[32:63], req_data[32:63]};
  // Word reads keep only the low word of the returned data.
  assign rdata = mmio_reg.doubleword ? mmio_in.data : {32'h0, mmio_in.data[32:63]};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: state_next = WAIT;
      WAIT: if (ack_taken || expire) state_next = DONE;
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request register: loaded on accept, valid lasts for the ISSUE cycle only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mmio_reg <= '0;
    end else begin
      mmio_reg.valid <= accept;
      if (accept) begin
        mmio_reg.cfg            <= req_cfg;
        mmio_reg.read           <= req_read;
        mmio_reg.doubleword     <= req_doubleword;
        mmio_reg.address        <= req_address;
        mmio_reg.address_parity <= ~^req_address;
        mmio_reg.data           <= wdata;
        mmio_reg.data_parity    <= ~^wdata;
      end
    end
  end

  // Timeout counter: cleared while issuing, counts during WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                cnt_reg <= '0;
    else if (state_reg == ISSUE) cnt_reg <= '0;
    else if (state_reg == WAIT)  cnt_reg <= cnt_step;
  end

  // Response capture on ack (ack beats expiry) or on timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_data_reg       <= '0;
      resp_parity_err_reg <= 1'b0;
      resp_timeout_reg    <= 1'b0;
    end else if (ack_taken) begin
      resp_data_reg       <= mmio_reg.read ? rdata : 64'h0;
      resp_parity_err_reg <= mmio_reg.read && (mmio_in.data_parity != ~^mmio_in.data);
      resp_timeout_reg    <= 1'b0;
    end else if (expire) begin
      resp_data_reg       <= '0;
      resp_parity_err_reg <= 1'b0;
      resp_timeout_reg    <= 1'b1;
    end
  end

  // Any ack outside WAIT has no transaction to complete; flag it next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stray_reg <= 1'b0;
    else          stray_reg <= mmio_in.ack && (state_reg != WAIT);
  end

  assign mmio_out        = mmio_reg;
  assign resp_data       = resp_valid ? resp_data_reg : 64'h0;
  assign resp_parity_err = resp_valid && resp_parity_err_reg;
  assign resp_timeout    = resp_valid && resp_timeout_reg;
  assign stray_ack       = stray_reg;

endmodule

// File: tb/tb_mmio_requester.sv
// Bench for mmio_requester: directed commands with hand-computed request and
// response expectations pushed into queues; a monitor pops and compares.

module tb_mmio_requester;
  import mmio_pkg::*;

  localparam int TO = 8;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               req_cfg = 1'b0;
  logic               req_read = 1'b0;
  logic               req_doubleword = 1'b0;
  logic [0:23]        req_address = '0;
  logic [0:63]        req_data = '0;
  MMIOInterfaceInput  mmio_out;
  MMIOInterfaceOutput mmio_in = '0;
  logic               resp_valid;
  logic [0:63]        resp_data;
  logic               resp_parity_err;
  logic               resp_timeout;
  logic               stray_ack;

  mmio_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cfg(req_cfg),
    .req_read(req_read), .req_doubleword(req_doubleword),
    .req_address(req_address), .req_data(req_data),
    .mmio_out(mmio_out), .mmio_in(mmio_in),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_parity_err(resp_parity_err), .resp_timeout(resp_timeout),
    .stray_ack(stray_ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  kind;   // {cfg, read, doubleword}
    logic [0:23] addr;
    logic        ap;
    logic [0:63] data;
    logic        dp;
    int          c;
  } req_exp_t;

  typedef struct {
    logic [0:63] data;
    logic        perr;
    logic        to;
    int          c;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic exp_req(input logic [2:0] kind, input logic [0:23] addr, input logic ap,
                         input logic [0:63] data, input logic dp, input int c);
    req_exp_t e;
    e.kind = kind; e.addr = addr; e.ap = ap; e.data = data; e.dp = dp; e.c = c;
    req_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [0:63] data, input logic perr, input logic to, input int c);
    rsp_exp_t e;
    e.data = data; e.perr = perr; e.to = to; e.c = c;
    rsp_q.push_back(e);
  endtask

  // Monitor: compares every request pulse and every response pulse.
  logic outstanding = 1'b0;
  initial forever begin
    @(negedge clock);
    if (!reset_n) outstanding = 1'b0;
    if (mmio_out.valid) begin
      check("no_overlap", 64'(outstanding), 64'd0);
      outstanding = 1'b1;
      if (req_q.size() == 0) begin
        check("req_pending", 64'(req_q.size()), 64'd1);
      end else begin
        req_exp_t e;
        e = req_q.pop_front();
        check("req_kind", 64'({mmio_out.cfg, mmio_out.read, mmio_out.doubleword}), 64'(e.kind));
        check("req_addr", 64'(mmio_out.address), 64'(e.addr));
        check("req_addr_par", 64'(mmio_out.address_parity), 64'(e.ap));
        check("req_data", mmio_out.data, e.data);
        check("req_data_par", 64'(mmio_out.data_parity), 64'(e.dp));
        check("req_cycle", 64'(cyc), 64'(e.c));
        $display("req  cyc=%0d addr=%h data=%h", cyc, mmio_out.address, mmio_out.data);
      end
    end
    if (resp_valid) begin
      outstanding = 1'b0;
      if (rsp_q.size() == 0) begin
        check("rsp_pending", 64'(rsp_q.size()), 64'd1);
      end else begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        check("rsp_data", resp_data, e.data);
        check("rsp_perr", 64'(resp_parity_err), 64'(e.perr));
        check("rsp_timeout", 64'(resp_timeout), 64'(e.to));
        check("rsp_cycle", 64'(cyc), 64'(e.c));
        $display("resp cyc=%0d data=%h perr=%0b to=%0b", cyc, resp_data, resp_parity_err, resp_timeout);
      end
    end
  end

  // Present a command and wait (bounded) for acceptance; returns the ISSUE cycle.
  task automatic send_req(input logic cfg, input logic rd, input logic dw,
                          input logic [0:23] addr, input logic [0:63] data,
                          input bit hold, output int vcyc);
    bit acc = 0;
    int n = 0;
    req_valid = 1'b1; req_cfg = cfg; req_read = rd; req_doubleword = dw;
    req_address = addr; req_data = data;
    while (!acc && n < 50) begin
      acc = req_ready;
      @(posedge clock); #1;
      n++;
    end
    if (!acc) check("accept_bound", 64'(n), 64'd0);
    vcyc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  // Drive a one-cycle ack during cycle 'target'; returns in cycle target+1.
  task automatic ack_at(input int target, input logic [0:63] d, input logic p);
    while (cyc < target) begin @(posedge clock); #1; end
    mmio_in.ack = 1'b1; mmio_in.data = d; mmio_in.data_parity = p;
    @(posedge clock); #1;
    mmio_in = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 40) begin @(posedge clock); #1; n++; end
    check("ready_return", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v;
    #2;
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_mmio_valid", 64'(mmio_out.valid), 64'd0);
    check("reset_mmio_nonzero", 64'(mmio_out != '0), 64'd0);
    check("reset_stray", 64'(stray_ack), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: cfg dword read of address 0, ack two cycles after valid.
    send_req(1, 1, 1, 24'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, v);
    exp_req(3'b111, 24'h0, 1'b1, 64'h0, 1'b1, v);
    exp_rsp(64'h1, 1'b0, 1'b0, v + 3);
    ack_at(v + 2, 64'h1, 1'b0);
    @(negedge clock);
    check("legit_ack_no_stray", 64'(stray_ack), 64'd0);
    wait_ready();

    // 2: word write, low word replicated; returned ack data ignored.
    send_req(0, 0, 0, 24'h000010, 64'h0000_0000_DEAD_BEEF, 0, v);
    exp_req(3'b000, 24'h000010, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, v);
    exp_rsp(64'h0, 1'b0, 1'b0, v + 2);
    ack_at(v + 1, 64'h3, 1'b0);
    wait_ready();

    // 3: dword read with bad parity on returned data.
    send_req(0, 1, 1, 24'h000020, 64'h0, 0, v);
    exp_req(3'b011, 24'h000020, 1'b0, 64'h0, 1'b1, v);
    exp_rsp(64'h3, 1'b1, 1'b0, v + 2);
    ack_at(v + 1, 64'h3, 1'b0);
    wait_ready();

    // 3b: word read; upper half cleared in result but included in parity.
    send_req(0, 1, 0, 24'h000003, 64'h0, 0, v);
    exp_req(3'b010, 24'h000003, 1'b1, 64'h0, 1'b1, v);
    exp_rsp(64'h0000_0000_1234_5678, 1'b0, 1'b0, v + 2);
    ack_at(v + 1, 64'hFFFF_0001_1234_5678, 1'b1);
    wait_ready();

    // 3c: cfg dword write; ack carries bad-parity data which must be ignored.
    send_req(1, 0, 1, 24'hABCDEF, 64'h0123_4567_89AB_CDEF, 0, v);
    exp_req(3'b101, 24'hABCDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, v);
    exp_rsp(64'h0, 1'b0, 1'b0, v + 3);
    ack_at(v + 2, 64'h3, 1'b0);
    wait_ready();

    // 4: no ack -> timeout response TO cycles after valid, then stray ack in IDLE.
    send_req(0, 1, 1, 24'h000040, 64'h0, 0, v);
    exp_req(3'b011, 24'h000040, 1'b0, 64'h0, 1'b1, v);
    exp_rsp(64'h0, 1'b0, 1'b1, v + TO);
    wait_ready();
    ack_at(cyc, 64'h5, 1'b0);
    @(negedge clock);
    check("stray_after_timeout", 64'(stray_ack), 64'd1);
    check("idle_after_stray", 64'(req_ready), 64'd1);
    @(posedge clock); #1;

    // 4b: ack in the expiry cycle wins over timeout.
    send_req(0, 1, 1, 24'h000050, 64'h0, 0, v);
    exp_req(3'b011, 24'h000050, 1'b1, 64'h0, 1'b1, v);
    exp_rsp(64'h7, 1'b0, 1'b0, v + TO);
    ack_at(v + TO - 1, 64'h7, 1'b0);
    wait_ready();

    // 5: ack in the ISSUE cycle is stray; a later ack completes.
    send_req(0, 1, 1, 24'h000060, 64'h0, 0, v);
    exp_req(3'b011, 24'h000060, 1'b1, 64'h0, 1'b1, v);
    exp_rsp(64'h0, 1'b0, 1'b0, v + 3);
    mmio_in.ack = 1'b1; mmio_in.data = 64'h9; mmio_in.data_parity = 1'b1;
    @(posedge clock); #1;
    mmio_in = '0;
    @(negedge clock);
    check("stray_on_issue_ack", 64'(stray_ack), 64'd1);
    ack_at(v + 2, 64'h0, 1'b1);
    wait_ready();

    // 6: reset during WAIT aborts silently; a later ack is stray.
    send_req(0, 1, 1, 24'h000070, 64'h0, 0, v);
    exp_req(3'b011, 24'h000070, 1'b0, 64'h0, 1'b1, v);
    while (cyc < v + 2) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    check("midreset_mmio_valid", 64'(mmio_out.valid), 64'd0);
    check("midreset_mmio_nonzero", 64'(mmio_out != '0), 64'd0);
    check("midreset_ready", 64'(req_ready), 64'd1);
    check("midreset_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    ack_at(cyc, 64'h1, 1'b0);
    @(negedge clock);
    check("stray_after_reset", 64'(stray_ack), 64'd1);
    check("ready_after_reset", 64'(req_ready), 64'd1);
    @(posedge clock); #1;

    // 7: back-to-back with req_valid held; second issue only after DONE.
    send_req(0, 1, 0, 24'h000001, 64'h0, 1, v);
    exp_req(3'b010, 24'h000001, 1'b0, 64'h0, 1'b1, v);
    exp_rsp(64'h0000_0000_8000_0001, 1'b0, 1'b0, v + 2);
    req_cfg = 1'b0; req_read = 1'b0; req_doubleword = 1'b1;
    req_address = 24'hFFFFFF; req_data = 64'h0;
    exp_req(3'b001, 24'hFFFFFF, 1'b1, 64'h0, 1'b1, v + 4);
    exp_rsp(64'h0, 1'b0, 1'b0, v + 6);
    ack_at(v + 1, 64'hAAAA_AAAA_8000_0001, 1'b1);
    ack_at(v + 5, 64'h0, 1'b1);
    req_valid = 1'b0;
    wait_ready();
    repeat (3) @(posedge clock);
    #1;

    check("queues_drained", 64'(req_q.size() + rsp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
